// File: rtl/interval_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interval_sched_pkg
// Description : Shared types, defaults and the round-robin selection helper
//               for the interval scheduler.
//               - sched_state_e : 2-bit scheduler state (IDLE, RUN, DONE)
//               - c_default_nreq / c_default_n : default requester count and
//                 counter width
//               - rr_select() : one-hot round-robin pick from a request
//                 vector, searching upward from a pointer and wrapping
// Revision    : 1.0 - initial release
// ============================================================================
package interval_sched_pkg;

    localparam int c_default_nreq = 4;
    localparam int c_default_n    = 4;

    // The selection helper works on a fixed 8-bit vector (largest supported
    // requester count); callers zero-extend and slice.
    localparam int c_max_nreq     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

    // Returns a one-hot vector marking the first set request at or above
    // 'ptr', wrapping modulo 'nreq'. All-zero when no request is set.
    function automatic logic [c_max_nreq-1:0] rr_select(
        input logic [c_max_nreq-1:0] req,
        input logic [2:0]            ptr,
        input int                    nreq
    );
        logic [c_max_nreq-1:0] sel;
        logic                  found;
        logic [2:0]            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < c_max_nreq; k++) begin
            idx = 3'((int'(ptr) + k) % nreq);
            if ((k < nreq) && !found && req[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interval_counter.sv
`default_nettype none
// ============================================================================
// Module      : interval_counter
// Description : N-bit tick counter used by the interval scheduler. Clears on
//               'clr', advances on 'en', and flags the final tick of an
//               interval whose length is 'limit' (0 meaning 2^N ticks).
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-low reset
//               clr   - synchronous clear (wins over en)
//               en    - advance by one tick
//               limit - interval length, N bits
//               count - current tick index
//               last  - count == limit-1 (mod 2^N)
// Revision    : 1.0 - initial release
// ============================================================================
module interval_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic         last
);

    logic [N-1:0] r_count_q;
    logic [N-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (clr) begin
            w_count_d = '0;
        end else if (en) begin
            w_count_d = r_count_q + N'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign count = r_count_q;
    // Modular subtraction makes limit==0 map to the all-ones tick, giving a
    // full 2^N-tick interval without a special case.
    assign last  = (r_count_q == (limit - N'(1)));

endmodule
`default_nettype wire

// File: rtl/interval_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : interval_scheduler
// Description : Round-robin arbiter sharing one interval counter among NREQ
//               requesters. The winner owns the counter for 'len' ticks
//               (0 = 2^N), then receives a one-cycle 'done' pulse.
//               Optional feature macro: INTERVAL_SCHED_ABORT_EN - when
//               defined, the owner dropping its request during RUN abandons
//               the interval without a 'done' pulse.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-low reset
//               req   - per-requester request level (NREQ)
//               len   - packed interval lengths, slice i = len[i*N +: N]
//               grant - one-hot counter owner, or zero (NREQ)
//               done  - one-cycle completion pulse to the owner (NREQ)
//               busy  - counter owned (RUN or DONE)
//               count - tick index of the running interval (N)
// Revision    : 1.0 - initial release
// ============================================================================
module interval_scheduler
    import interval_sched_pkg::*;
#(
    parameter int NREQ = c_default_nreq,
    parameter int N    = c_default_n
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] len,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [N-1:0]      count
);

    localparam int c_idx_w = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_e          r_state_q,  w_state_d;
    logic [NREQ-1:0]       r_grant_q,  w_grant_d;
    logic [NREQ-1:0]       r_done_q,   w_done_d;
    logic                  r_busy_q,   w_busy_d;
    logic [c_idx_w-1:0]    r_ptr_q,    w_ptr_d;
    logic [c_idx_w-1:0]    r_winner_q, w_winner_d;
    logic [N-1:0]          r_limit_q,  w_limit_d;

    logic [c_max_nreq-1:0] w_sel_full;
    logic [NREQ-1:0]       w_sel;
    logic [c_idx_w-1:0]    w_sel_idx;
    logic [N-1:0]          w_sel_len;
    logic [c_idx_w-1:0]    w_ptr_next;
    logic                  w_cnt_clr;
    logic                  w_cnt_en;
    logic                  w_cnt_last;
    logic                  w_abort;

    // ------------------------------------------------------------------
    // Round-robin pick, evaluated every cycle but only acted on in IDLE
    // ------------------------------------------------------------------
    assign w_sel_full = rr_select(c_max_nreq'(req), 3'(r_ptr_q), NREQ);
    assign w_sel      = w_sel_full[NREQ-1:0];

    generate
        if (NREQ < c_max_nreq) begin : g_sel_pad
            // Upper bits are always zero because the search is bounded by NREQ.
            logic w_unused_sel_hi;
            assign w_unused_sel_hi = |w_sel_full[c_max_nreq-1:NREQ];
        end
    endgenerate

    always_comb begin
        w_sel_idx = '0;
        w_sel_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel[i]) begin
                w_sel_idx = c_idx_w'(i);
                w_sel_len = len[i*N +: N];
            end
        end
    end

    assign w_ptr_next = (r_winner_q == c_idx_w'(NREQ - 1)) ? '0
                                                           : r_winner_q + c_idx_w'(1);

`ifdef INTERVAL_SCHED_ABORT_EN
    // Owner has withdrawn its request while the interval is running.
    assign w_abort = ~|(req & r_grant_q);
`else
    assign w_abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic; every output is taken straight from a flop
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_grant_d  = r_grant_q;
        w_done_d   = '0;
        w_busy_d   = r_busy_q;
        w_ptr_d    = r_ptr_q;
        w_winner_d = r_winner_q;
        w_limit_d  = r_limit_q;
        w_cnt_clr  = 1'b0;
        w_cnt_en   = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (|req) begin
                    w_state_d  = ST_RUN;
                    w_grant_d  = w_sel;
                    w_busy_d   = 1'b1;
                    w_winner_d = w_sel_idx;
                    w_limit_d  = w_sel_len;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_d = ST_IDLE;
                    w_grant_d = '0;
                    w_busy_d  = 1'b0;
                    w_ptr_d   = w_ptr_next;
                    w_cnt_clr = 1'b1;
                end else if (w_cnt_last) begin
                    // Counter stops here so the final tick stays visible in DONE.
                    w_state_d = ST_DONE;
                    w_done_d  = r_grant_q;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
                w_grant_d = '0;
                w_busy_d  = 1'b0;
                w_ptr_d   = w_ptr_next;
                w_cnt_clr = 1'b1;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_grant_d = '0;
                w_busy_d  = 1'b0;
                w_cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q  <= ST_IDLE;
            r_grant_q  <= '0;
            r_done_q   <= '0;
            r_busy_q   <= 1'b0;
            r_ptr_q    <= '0;
            r_winner_q <= '0;
            r_limit_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_grant_q  <= w_grant_d;
            r_done_q   <= w_done_d;
            r_busy_q   <= w_busy_d;
            r_ptr_q    <= w_ptr_d;
            r_winner_q <= w_winner_d;
            r_limit_q  <= w_limit_d;
        end
    end

    interval_counter #(
        .N (N)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .limit (r_limit_q),
        .count (count),
        .last  (w_cnt_last)
    );

    assign grant = r_grant_q;
    assign done  = r_done_q;
    assign busy  = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_interval_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_interval_scheduler
// Description : Self-checking bench for interval_scheduler (NREQ=4, N=4).
//               Scenario drivers push the expected service sequence into a
//               scoreboard queue; a negedge monitor follows each grant and
//               pops/compares when 'done' fires or the grant ends early.
//               Honours INTERVAL_SCHED_ABORT_EN for the abort scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_scheduler;

    localparam int NREQ = 4;
    localparam int N    = 4;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req   = '0;
    logic [NREQ*N-1:0] len   = '0;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [N-1:0]      count;

    typedef struct {
        int idx;
        int len;
        int gap;      // required cycles since the previous done, 0 = unchecked
        bit abort;    // service is expected to end without done
        int abort_k;  // granted cycles before an abort
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done_cyc = 0;

    bit              svc_on   = 1'b0;
    bit              svc_done = 1'b0;
    int              svc_k    = 0;
    int              svc_busy = 0;
    int              svc_len  = 0;
    logic [NREQ-1:0] svc_grant = '0;

    interval_scheduler #(
        .NREQ (NREQ),
        .N    (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void push_exp(int idx, int l, int gap, bit abort, int abort_k);
        exp_t e;
        e.idx     = idx;
        e.len     = l;
        e.gap     = gap;
        e.abort   = abort;
        e.abort_k = abort_k;
        sb_q.push_back(e);
    endfunction

    task automatic set_len(input int l0, input int l1, input int l2, input int l3);
        len = {4'(l3), 4'(l2), 4'(l1), 4'(l0)};
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard consumer
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        int   l;
        cyc++;
        if (!reset) begin
            svc_on   = 1'b0;
            svc_done = 1'b0;
        end else begin
            check_eq("grant_at_most_one", 32'($countones(grant) <= 1), 1);
            check_eq("done_within_grant", 32'((done & ~grant) == '0), 1);
            if (svc_on && grant == '0) begin
                if (svc_done) begin
                    check_eq("granted_cycles", svc_k, svc_len + 1);
                    check_eq("busy_cycles", svc_busy, svc_len + 1);
                end else begin
                    check_eq("sb_nonempty_at_abort", 32'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check_eq("abort_expected", 32'(e.abort), 1);
                        check_eq("abort_owner", 32'(svc_grant), 1 << e.idx);
                        check_eq("abort_cycles", svc_k, e.abort_k);
                    end
                end
                check_eq("idle_busy", 32'(busy), 0);
                check_eq("idle_count", 32'(count), 0);
                svc_on = 1'b0;
            end else if (!svc_on && grant != '0) begin
                svc_on    = 1'b1;
                svc_done  = 1'b0;
                svc_k     = 0;
                svc_busy  = 0;
                svc_grant = grant;
            end
            if (svc_on) begin
                svc_k++;
                if (busy) svc_busy++;
                check_eq("grant_hold", 32'(grant), 32'(svc_grant));
                if (done != '0) begin
                    check_eq("one_done_per_grant", 32'(svc_done), 0);
                    check_eq("sb_nonempty_at_done", 32'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        l = (e.len == 0) ? (1 << N) : e.len;
                        check_eq("done_onehot", 32'(done), 1 << e.idx);
                        check_eq("done_owner", 32'(svc_grant), 1 << e.idx);
                        check_eq("done_not_aborted", 32'(e.abort), 0);
                        check_eq("run_cycles", svc_k - 1, l);
                        check_eq("final_count", 32'(count), l - 1);
                        if (e.gap != 0) check_eq("done_spacing", cyc - last_done_cyc, e.gap);
                        svc_len = l;
                    end
                    svc_done      = 1'b1;
                    last_done_cyc = cyc;
                end else if (!svc_done) begin
                    check_eq("count_tick", 32'(count), svc_k - 1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic reset_dut();
        reset = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_count", 32'(count), 0);
        reset = 1'b1;
    endtask

    // Requester i asks n_i times, dropping its request after its last done.
    task automatic serve(input int n0, input int n1, input int n2, input int n3,
                         input bit scramble, input int budget);
        int rem[NREQ];
        int left;
        bit scrambled;
        rem[0] = n0; rem[1] = n1; rem[2] = n2; rem[3] = n3;
        scrambled = 1'b0;
        left = budget;
        for (int i = 0; i < NREQ; i++) req[i] = (rem[i] > 0);
        while ((rem[0] + rem[1] + rem[2] + rem[3]) > 0 && left > 0) begin
            @(negedge clk);
            left--;
            if (scramble && !scrambled && grant != '0) begin
                // Owner's len changes after grant; the interval must not notice.
                for (int i = 0; i < NREQ; i++)
                    if (grant[i]) len[i*N +: N] = ~len[i*N +: N];
                scrambled = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (done[i] && rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) req[i] = 1'b0;
                end
            end
        end
        check_eq("serve_in_budget", 32'((rem[0] + rem[1] + rem[2] + rem[3]) == 0), 1);
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  left;
        bit  dropped;
        bit  got2;

        // Single request, len changed after grant
        reset_dut();
        set_len(3, 0, 0, 0);
        push_exp(0, 3, 0, 1'b0, 0);
        serve(1, 0, 0, 0, 1'b1, 40);

        // Zero length -> 16-tick interval
        reset_dut();
        set_len(5, 5, 0, 5);
        push_exp(2, 0, 0, 1'b0, 0);
        serve(0, 0, 1, 0, 1'b0, 60);

        // All requesting
        reset_dut();
        set_len(2, 2, 2, 2);
        push_exp(0, 2, 0, 1'b0, 0);
        push_exp(1, 2, 4, 1'b0, 0);
        push_exp(2, 2, 4, 1'b0, 0);
        push_exp(3, 2, 4, 1'b0, 0);
        serve(1, 1, 1, 1, 1'b0, 80);

        // Fairness between 0 and 2
        reset_dut();
        set_len(1, 1, 1, 1);
        push_exp(0, 1, 0, 1'b0, 0);
        push_exp(2, 1, 3, 1'b0, 0);
        push_exp(0, 1, 3, 1'b0, 0);
        push_exp(2, 1, 3, 1'b0, 0);
        serve(2, 0, 2, 0, 1'b0, 80);

        // Reset in the middle of a run
        reset_dut();
        set_len(0, 9, 0, 2);
        req  = 4'b0010;
        left = 40;
        while (!(grant[1] && count == 4'd5) && left > 0) begin
            @(negedge clk);
            left--;
        end
        check_eq("reach_count5", 32'(grant[1] && count == 4'd5), 1);
        reset = 1'b0;
        #1;
        check_eq("async_rst_grant", 32'(grant), 0);
        check_eq("async_rst_done", 32'(done), 0);
        check_eq("async_rst_busy", 32'(busy), 0);
        check_eq("async_rst_count", 32'(count), 0);
        req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        set_len(0, 2, 0, 2);
        push_exp(1, 2, 0, 1'b0, 0);
        push_exp(3, 2, 4, 1'b0, 0);
        serve(0, 1, 0, 1, 1'b0, 60);

        // Owner drops its request mid-run
        reset_dut();
        set_len(0, 8, 2, 0);
`ifdef INTERVAL_SCHED_ABORT_EN
        push_exp(1, 8, 0, 1'b1, 2);
`else
        push_exp(1, 8, 0, 1'b0, 0);
`endif
        push_exp(2, 2, 0, 1'b0, 0);
        req     = 4'b0110;
        dropped = 1'b0;
        got2    = 1'b0;
        left    = 80;
        while (left > 0 && !got2) begin
            @(negedge clk);
            left--;
            if (!dropped && grant[1] && count == 4'd1) begin
                req[1]  = 1'b0;
                dropped = 1'b1;
            end
            if (done[2]) begin
                req[2] = 1'b0;
                got2   = 1'b1;
            end
        end
        check_eq("abort_flow_in_budget", 32'(got2), 1);
        req = '0;
        repeat (3) @(negedge clk);

        check_eq("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
